action_selector: RTL
====================

// Module: action_selector
// PURPOSE
//  Agent-side counterpart of the grid environment checker: consumes the current state (curr_state +
//  decoder_en strobe) and produces the next action (act) plus the episode-restart request
//  (change_iteration) the checker consumes. Reads the 4 Q-values of the current state from the
//  Q-table and applies epsilon-greedy selection. Sits between the Q-table memory and the checker.
// PARAMETERS
//  STATE_W     5       state index width (5x5 grid, states 0..24)
//  Q_W         16      signed Q-value width
//  GOAL_STATE  24      terminal state; reaching it ends the episode
//  MAX_STEPS   64      decisions per episode before forced restart (>=1)
//  EPSILON     26      9-bit explore threshold; explore if {1'b0,lfsr[7:0]} < EPSILON (0=never, 256=always)
//  LFSR_SEED   16'hACE1 nonzero LFSR reset value
// PORTS
//  clk              in   1        clock
//  rst              in   1        synchronous active-high reset
//  curr_state       in   STATE_W  current environment state, valid when decoder_en=1
//  decoder_en       in   1        state-valid strobe from checker
//  greedy_only      in   1        1 = force exploitation (ignore EPSILON)
//  q_rd_en          out  1        Q-table read enable
//  q_rd_addr        out  STATE_W+2 read address = {state, action}
//  q_rd_data        in   Q_W      signed read data, valid 1 cycle after q_rd_en
//  act              out  2        selected action, held until next decision
//  act_valid        out  1        1-cycle pulse: act/change_iteration valid
//  change_iteration out  1        episode restart request, asserted only with act_valid
//  busy             out  1        1 whenever FSM not IDLE
//  ep_cnt           out  16       completed episodes, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (sync, rst=1): all outputs 0, FSM->IDLE, step_cnt=0, lfsr=LFSR_SEED; dominates every input.
//  Reset mid-operation abandons outstanding reads; late q_rd_data ignored.
//  FSM: IDLE -> READ -> DRAIN -> ISSUE -> IDLE; IDLE -> ISSUE directly on goal.
//   IDLE: on decoder_en latch curr_state. If state==GOAL_STATE -> ISSUE (goal path), else -> READ.
//    decoder_en while busy=1 is ignored (no queueing).
//   READ: 4 cycles, a_idx 0..3; q_rd_en=1, q_rd_addr={st,a_idx}.
//   Compare pipelined: data for a_idx arrives next cycle; best updated only on strict signed
//    greater -> ties resolve to lowest action index. Action 0 data initialises best.
//   DRAIN: capture action-3 data; sample explore = !greedy_only && ({1'b0,lfsr[7:0]} < EPSILON);
//    explore -> act_next = lfsr[9:8], else argmax.
//   ISSUE: act_valid=1 for one cycle, act updated; change_iteration=1 if goal path or
//    step_cnt==MAX_STEPS-1. Goal path: act=0, no Q reads.
//  Latency: decoder_en at T -> reads T+1..T+4 -> act_valid T+6 (normal); T+1 (goal path).
//  step_cnt: +1 per non-restart issue; cleared on issue with change_iteration=1.
//  ep_cnt: +1 on each change_iteration issue, saturating.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11, steps every cycle after reset (free-running).
//  act, change_iteration hold last values between issues; change_iteration clears in cycle after ISSUE.
// STRUCTURE
//  Shared package ql_pkg: STATE_W, ACT_W=2, N_ACT=4, action codes ACT_RIGHT=0 (+1), ACT_UP=1 (-5),
//   ACT_LEFT=2 (-1), ACT_DOWN=3 (+5), Q-table address function {state,action}, FSM state encoding.
//  Sub-module: lfsr16 (seed param, enable, 16-bit out), shared with other random-consuming blocks.
// TESTING
//  1 rst high 3 cycles mid-READ -> next cycle all outputs 0, busy=0, q_rd_en=0, ep_cnt=0.
//  2 greedy_only=1, curr_state=6, Q[24..27]={5,-3,12,12} -> addrs 24,25,26,27 at T+1..T+4,
//    act=2 with act_valid at T+6, change_iteration=0.
//  3 greedy_only=1, all four Q=-7 -> act=0; Q={-9,-2,-5,-8} -> act=1 (signed compare).
//  4 curr_state=24 with decoder_en -> no q_rd_en, act_valid at T+1, act=0, change_iteration=1, ep_cnt 0->1.
//  5 MAX_STEPS=4, four decisions from state 1 -> 4th issue has change_iteration=1, step_cnt->0;
//    decoder_en pulsed while busy -> no extra decision.
//  6 EPSILON=256, 1000 decisions -> act == lfsr[9:8] per scoreboard model, all 4 actions seen;
//    EPSILON=0 -> act always equals argmax.

Source files
------------

// File: rtl/ql_pkg.sv
// Shared Q-learning definitions: grid and action encoding, Q-table address
// layout, and the action selector FSM state codes.
package ql_pkg;

  localparam int STATE_W = 5;
  localparam int ACT_W   = 2;
  localparam int N_ACT   = 4;

  // Action codes and the state-index move each one makes on the 5x5 grid.
  localparam logic [ACT_W-1:0] ACT_RIGHT = 2'd0;  // +1
  localparam logic [ACT_W-1:0] ACT_UP    = 2'd1;  // -5
  localparam logic [ACT_W-1:0] ACT_LEFT  = 2'd2;  // -1
  localparam logic [ACT_W-1:0] ACT_DOWN  = 2'd3;  // +5

  // Action selector FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_ISSUE = 2'd3;

  // Q-table entries are laid out as {state, action}.
  function automatic logic [STATE_W+ACT_W-1:0] q_addr(
    input logic [STATE_W-1:0] state,
    input logic [ACT_W-1:0]   action
  );
    return {state, action};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
// Shared by every block that needs cheap pseudo-random bits.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_r;
  logic        feedback_s;

  assign feedback_s = lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5];
  assign lfsr       = lfsr_r;

  // Load the seed on reset, otherwise shift in the feedback bit when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= SEED;
    end else if (en) begin
      lfsr_r <= {feedback_s, lfsr_r[15:1]};
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

endmodule

// File: rtl/action_selector.sv
// Epsilon-greedy action selector: reads the four Q-values of the current
// state, picks the argmax (lowest index on ties) or a random action, and
// flags episode restarts on goal or when the step budget runs out.
module action_selector #(
  parameter int          STATE_W    = 5,
  parameter int          Q_W        = 16,
  parameter int          GOAL_STATE = 24,
  parameter int          MAX_STEPS  = 64,
  parameter int          EPSILON    = 26,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STATE_W-1:0]        curr_state,
  input  logic                      decoder_en,
  input  logic                      greedy_only,
  output logic                      q_rd_en,
  output logic [STATE_W+1:0]        q_rd_addr,
  input  logic signed [Q_W-1:0]     q_rd_data,
  output logic [1:0]                act,
  output logic                      act_valid,
  output logic                      change_iteration,
  output logic                      busy,
  output logic [15:0]               ep_cnt
);

  import ql_pkg::*;

  localparam int         SC_W  = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
  localparam logic [8:0] EPS_9 = 9'(EPSILON);

  logic [1:0]            state_r;
  logic [STATE_W-1:0]    st_r;
  logic [1:0]            a_idx_r;
  logic signed [Q_W-1:0] best_val_r;
  logic [1:0]            best_idx_r;
  logic [SC_W-1:0]       step_cnt_r;

  logic                  q_rd_en_r;
  logic [STATE_W+1:0]    q_rd_addr_r;
  logic [1:0]            act_r;
  logic                  act_valid_r;
  logic                  change_iteration_r;
  logic                  busy_r;
  logic [15:0]           ep_cnt_r;

  logic [15:0]           lfsr_s;
  logic                  unused_lfsr_s;
  logic                  greater_s;
  logic [1:0]            final_idx_s;
  logic                  explore_s;
  logic [1:0]            act_next_s;
  logic                  last_step_s;
  logic                  is_goal_s;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .lfsr (lfsr_s)
  );

  // Only the low ten LFSR bits feed the decision.
  assign unused_lfsr_s = ^lfsr_s[15:10];

  assign q_rd_en          = q_rd_en_r;
  assign q_rd_addr        = q_rd_addr_r;
  assign act              = act_r;
  assign act_valid        = act_valid_r;
  assign change_iteration = change_iteration_r;
  assign busy             = busy_r;
  assign ep_cnt           = ep_cnt_r;

  // Compare the arriving Q-value, and form the final action and restart decision.
  always_comb begin
    greater_s = (q_rd_data > best_val_r);
    if (greater_s) begin
      final_idx_s = 2'd3;
    end else begin
      final_idx_s = best_idx_r;
    end
    explore_s = !greedy_only && ({1'b0, lfsr_s[7:0]} < EPS_9);
    if (explore_s) begin
      act_next_s = lfsr_s[9:8];
    end else begin
      act_next_s = final_idx_s;
    end
    last_step_s = (step_cnt_r == SC_W'(MAX_STEPS - 1));
    is_goal_s   = (curr_state == STATE_W'(GOAL_STATE));
  end

  // Decision FSM: accept a state, stream four Q reads, pick, issue one pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r            <= ST_IDLE;
      st_r               <= '0;
      a_idx_r            <= 2'd0;
      best_val_r         <= '0;
      best_idx_r         <= 2'd0;
      step_cnt_r         <= '0;
      q_rd_en_r          <= 1'b0;
      q_rd_addr_r        <= '0;
      act_r              <= 2'd0;
      act_valid_r        <= 1'b0;
      change_iteration_r <= 1'b0;
      busy_r             <= 1'b0;
      ep_cnt_r           <= 16'd0;
    end else begin
      act_valid_r        <= 1'b0;
      change_iteration_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (decoder_en) begin
            st_r   <= curr_state;
            busy_r <= 1'b1;
            if (is_goal_s) begin
              // Goal reached: restart immediately without touching the Q-table.
              state_r            <= ST_ISSUE;
              act_r              <= ACT_RIGHT;
              act_valid_r        <= 1'b1;
              change_iteration_r <= 1'b1;
              step_cnt_r         <= '0;
              if (ep_cnt_r != 16'hFFFF) begin
                ep_cnt_r <= ep_cnt_r + 16'd1;
              end else begin
                ep_cnt_r <= ep_cnt_r;
              end
            end else begin
              state_r     <= ST_READ;
              a_idx_r     <= 2'd0;
              q_rd_en_r   <= 1'b1;
              q_rd_addr_r <= q_addr(curr_state, 2'd0);
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          // Data on q_rd_data belongs to the action read in the previous cycle.
          case (a_idx_r)
            2'd0: begin
            end
            2'd1: begin
              best_val_r <= q_rd_data;
              best_idx_r <= 2'd0;
            end
            default: begin
              if (greater_s) begin
                best_val_r <= q_rd_data;
                best_idx_r <= a_idx_r - 2'd1;
              end else begin
                best_val_r <= best_val_r;
              end
            end
          endcase
          if (a_idx_r == 2'd3) begin
            state_r   <= ST_DRAIN;
            q_rd_en_r <= 1'b0;
          end else begin
            a_idx_r     <= a_idx_r + 2'd1;
            q_rd_addr_r <= q_addr(st_r, a_idx_r + 2'd1);
          end
        end
        ST_DRAIN: begin
          state_r            <= ST_ISSUE;
          act_r              <= act_next_s;
          act_valid_r        <= 1'b1;
          change_iteration_r <= last_step_s;
          if (last_step_s) begin
            step_cnt_r <= '0;
            if (ep_cnt_r != 16'hFFFF) begin
              ep_cnt_r <= ep_cnt_r + 16'd1;
            end else begin
              ep_cnt_r <= ep_cnt_r;
            end
          end else begin
            step_cnt_r <= step_cnt_r + 1'b1;
          end
        end
        ST_ISSUE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          q_rd_en_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
